// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// default timing constants for a 50 MHz system clock.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    REL_SPI,
    WAIT_INIT,
    REL_DISP,
    RUN,
    FAULT
  } state_t;

  localparam int unsigned DEF_SYS_CLK_SPEED       = 50_000_000;
  localparam int unsigned DEF_HOLD_CYCLES         = 20;
  localparam int unsigned DEF_DEBOUNCE_CYCLES     = 500_000;
  localparam int unsigned DEF_INIT_TIMEOUT_CYCLES = 5_000_000;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus saturating debounce counter for an active-low
// pushbutton; emits one btn_req pulse per press. DEBOUNCE_CYCLES must be >= 2.
module btn_debounce
  import rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic btn_req
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_CYCLES - 2);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser to one stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      cnt_q   <= '0;
      btn_req <= 1'b0;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
      if (sync_q2)
        cnt_q <= '0;
      else if (cnt_q != CNT_LAST)
        cnt_q <= cnt_q + 1'b1;
      // Fires on the edge where the count steps onto its saturation value.
      btn_req <= ~sync_q2 && (cnt_q == CNT_PRE);
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Power-on / pushbutton reset sequencer: holds SPI and display resets, starts
// accelerometer init, retries on timeout and parks in FAULT after MAX_RETRIES.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYS_CLK_SPEED       = DEF_SYS_CLK_SPEED,
  parameter int unsigned HOLD_CYCLES         = DEF_HOLD_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned INIT_TIMEOUT_CYCLES = DEF_INIT_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  input  logic init_done,
  output logic spi_rst,
  output logic disp_rst,
  output logic init_start,
  output logic sys_ready,
  output logic init_fault
);

  localparam int unsigned CNT_MAX = max2(HOLD_CYCLES, INIT_TIMEOUT_CYCLES);
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(INIT_TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          btn_req;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_n  (btn_n),
    .btn_req(btn_req)
  );

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (btn_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = REL_SPI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REL_SPI: begin
          state_d = WAIT_INIT;
          cnt_d   = '0;
        end
        WAIT_INIT: begin
          // init_done is tested first so it wins a tie with the timeout.
          if (init_done) begin
            state_d = REL_DISP;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d   = '0;
            retry_d = retry_q + 1'b1;
            state_d = (32'(retry_q) + 32'd1 < MAX_RETRIES) ? HOLD : FAULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REL_DISP: state_d = RUN;
        RUN:      state_d = RUN;
        FAULT:    state_d = FAULT;
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register, without a combinational path to the pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      retry_q    <= '0;
      spi_rst    <= 1'b1;
      disp_rst   <= 1'b1;
      init_start <= 1'b0;
      sys_ready  <= 1'b0;
      init_fault <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      spi_rst    <= (state_d == HOLD) || (state_d == FAULT);
      disp_rst   <= (state_d == HOLD) || (state_d == REL_SPI) ||
                    (state_d == WAIT_INIT) || (state_d == FAULT);
      init_start <= (state_d == REL_SPI);
      sys_ready  <= (state_d == RUN);
      init_fault <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with short timing parameters; expected
// edge numbers are hand-derived and counted from reset release.
module tb_rst_sequencer;

  localparam int H = 20;
  localparam int D = 4;
  localparam int T = 16;
  localparam int R = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_n = 1'b1;
  logic init_done = 1'b0;
  logic spi_rst, disp_rst, init_start, sys_ready, init_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .SYS_CLK_SPEED      (100_000_000),
    .HOLD_CYCLES        (H),
    .DEBOUNCE_CYCLES    (D),
    .INIT_TIMEOUT_CYCLES(T),
    .MAX_RETRIES        (R)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_n     (btn_n),
    .init_done (init_done),
    .spi_rst   (spi_rst),
    .disp_rst  (disp_rst),
    .init_start(init_start),
    .sys_ready (sys_ready),
    .init_fault(init_fault)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulses reset for one cycle and releases it on a falling edge, so the next
  // rising edge is edge 1 of the sequence.
  task automatic start_from_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    tick();
    checks++;
    if ({spi_rst, disp_rst, init_start, sys_ready, init_fault} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 11000",
               {spi_rst, disp_rst, init_start, sys_ready, init_fault});
    end
  endtask

  task automatic test_normal();
    int pulses = 0;
    init_done = 1'b0;
    start_from_reset();
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (init_start) pulses++;
    end
    checks++;
    if (spi_rst !== 1'b1 || disp_rst !== 1'b1) begin
      errors++;
      $display("FAIL normal_hold_e19: spi_rst=%b disp_rst=%b expected 1 1", spi_rst, disp_rst);
    end
    tick();
    checks++;
    if (spi_rst !== 1'b0 || init_start !== 1'b1 || disp_rst !== 1'b1) begin
      errors++;
      $display("FAIL normal_rel_spi_e20: spi=%b start=%b disp=%b expected 0 1 1",
               spi_rst, init_start, disp_rst);
    end
    if (init_start) pulses++;
    for (int e = 21; e <= 25; e++) begin
      tick();
      if (init_start) pulses++;
    end
    init_done = 1'b1;
    checks++;
    if (disp_rst !== 1'b1) begin
      errors++;
      $display("FAIL normal_disp_held_e25: got %b expected 1", disp_rst);
    end
    tick();
    if (init_start) pulses++;
    checks++;
    if (disp_rst !== 1'b0 || sys_ready !== 1'b0) begin
      errors++;
      $display("FAIL normal_rel_disp_e26: disp=%b ready=%b expected 0 0", disp_rst, sys_ready);
    end
    tick();
    if (init_start) pulses++;
    checks++;
    if (sys_ready !== 1'b1) begin
      errors++;
      $display("FAIL normal_ready_e27: got %b expected 1", sys_ready);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL normal_start_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_glitch();
    int drops = 0;
    btn_n = 1'b0;
    tick();
    tick();
    btn_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sys_ready !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL glitch_ready_drops: got %0d expected 0", drops);
    end
    init_done = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (sys_ready !== 1'b1 || spi_rst !== 1'b0 || disp_rst !== 1'b0) begin
      errors++;
      $display("FAIL run_ignores_init_done: ready=%b spi=%b disp=%b expected 1 0 0",
               sys_ready, spi_rst, disp_rst);
    end
  endtask

  // Three attempts at a 37-edge period: init_start at 20, 57, 94; FAULT at 111.
  task automatic test_timeout();
    int pulses = 0;
    int fault_edge = 0;
    init_done = 1'b0;
    start_from_reset();
    for (int e = 1; e <= 130; e++) begin
      tick();
      if (init_start) pulses++;
      if (init_fault && fault_edge == 0) fault_edge = e;
      if (e == 36) begin
        checks++;
        if (spi_rst !== 1'b0) begin
          errors++;
          $display("FAIL timeout_spi_e36: got %b expected 0", spi_rst);
        end
      end
      if (e == 37) begin
        checks++;
        if (spi_rst !== 1'b1) begin
          errors++;
          $display("FAIL timeout_spi_reassert_e37: got %b expected 1", spi_rst);
        end
      end
      if (e == 57) begin
        checks++;
        if (init_start !== 1'b1) begin
          errors++;
          $display("FAIL timeout_second_start_e57: got %b expected 1", init_start);
        end
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL timeout_start_pulses: got %0d expected 3", pulses);
    end
    checks++;
    if (fault_edge != 111) begin
      errors++;
      $display("FAIL timeout_fault_edge: got %0d expected 111", fault_edge);
    end
    checks++;
    if ({init_fault, spi_rst, disp_rst, sys_ready} !== 4'b1110) begin
      errors++;
      $display("FAIL fault_outputs: got %b expected 1110",
               {init_fault, spi_rst, disp_rst, sys_ready});
    end
  endtask

  // btn_req fires on edge 5 after btn_n falls, FSM enters HOLD on edge 6,
  // spi_rst falls with the new init_start 20 edges later.
  task automatic test_fault_restart();
    int pulses = 0;
    btn_n = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 10) btn_n = 1'b1;
      if (init_start) pulses++;
      if (e == 5) begin
        checks++;
        if (init_fault !== 1'b1) begin
          errors++;
          $display("FAIL restart_fault_e5: got %b expected 1", init_fault);
        end
      end
      if (e == 6) begin
        checks++;
        if (init_fault !== 1'b0 || spi_rst !== 1'b1) begin
          errors++;
          $display("FAIL restart_hold_e6: fault=%b spi=%b expected 0 1", init_fault, spi_rst);
        end
      end
      if (e == 25) begin
        checks++;
        if (spi_rst !== 1'b1 || init_start !== 1'b0) begin
          errors++;
          $display("FAIL restart_hold_e25: spi=%b start=%b expected 1 0", spi_rst, init_start);
        end
      end
      if (e == 26) begin
        checks++;
        if (spi_rst !== 1'b0 || init_start !== 1'b1) begin
          errors++;
          $display("FAIL restart_start_e26: spi=%b start=%b expected 0 1", spi_rst, init_start);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL restart_start_pulses: got %0d expected 1", pulses);
    end
  endtask

  // Reset lands in the second attempt (retry_cnt=1); a cleared retry count
  // means FAULT again arrives at edge 111 after release, not at 74.
  task automatic test_async_reset();
    int fault_edge = 0;
    init_done = 1'b0;
    start_from_reset();
    for (int e = 1; e <= 60; e++) tick();
    checks++;
    if (spi_rst !== 1'b0) begin
      errors++;
      $display("FAIL areset_pre_spi: got %b expected 0", spi_rst);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (spi_rst !== 1'b1 || disp_rst !== 1'b1 || init_fault !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: spi=%b disp=%b fault=%b expected 1 1 0",
               spi_rst, disp_rst, init_fault);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 115; e++) begin
      tick();
      if (init_fault && fault_edge == 0) fault_edge = e;
    end
    checks++;
    if (fault_edge != 111) begin
      errors++;
      $display("FAIL areset_retry_cleared: fault edge %0d expected 111", fault_edge);
    end
  endtask

  task automatic test_coincide();
    int pulses = 0;
    init_done = 1'b0;
    start_from_reset();
    for (int e = 1; e <= 36; e++) begin
      tick();
      if (init_start) pulses++;
    end
    init_done = 1'b1;
    tick();
    if (init_start) pulses++;
    checks++;
    if (spi_rst !== 1'b0 || disp_rst !== 1'b0 || init_fault !== 1'b0) begin
      errors++;
      $display("FAIL coincide_rel_disp_e37: spi=%b disp=%b fault=%b expected 0 0 0",
               spi_rst, disp_rst, init_fault);
    end
    tick();
    if (init_start) pulses++;
    checks++;
    if (sys_ready !== 1'b1) begin
      errors++;
      $display("FAIL coincide_ready_e38: got %b expected 1", sys_ready);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL coincide_start_pulses: got %0d expected 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_glitch();
    test_timeout();
    test_fault_restart();
    test_async_reset();
    test_coincide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
